board_ctrl: RTL and testbench

Owns the 10x20 Tetris playfield and its BCD score, and schedules every access to them. It serves the VGA display's per-pixel cell lookup (tetris_x/tetris_y -> kind) every cycle, accepts single-cell writes from game logic, and on a commit runs a scan/shift sequencer that removes full rows and updates the 4-digit BCD score. The score feeds the display's scoreboard digits. The sequencer and game writes share one row-write path; board_ctrl arbitrates between them.

---
 rtl/board_pkg.sv | 45 ++++
 rtl/bcd_inc4.sv | 29 ++
 rtl/board_ctrl.sv | 129 ++++++++++++
 tb/tb_board_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared playfield geometry, sequencer states and row/cell helpers for board_ctrl.
// Ports: none (package only).
// Cells are KIND_W bits packed into one row word, column 0 in the low bits.
package board_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  localparam int KIND_W  = 3;
  localparam int ROW_W   = BOARD_W * KIND_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A row is full when no cell holds kind 0.
  function automatic logic row_full(input logic [ROW_W-1:0] row);
    row_full = 1'b1;
    for (int i = 0; i < BOARD_W; i++) begin
      if (row[i*KIND_W +: KIND_W] == '0) row_full = 1'b0;
    end
  endfunction

  // Column lookup with an explicit compare chain so that out-of-range columns
  // never form an out-of-bounds part-select; they simply read as empty.
  function automatic logic [KIND_W-1:0] cell_at(input logic [ROW_W-1:0] row,
                                                input logic [3:0] x);
    cell_at = '0;
    for (int i = 0; i < BOARD_W; i++) begin
      if (32'(x) == i) cell_at = row[i*KIND_W +: KIND_W];
    end
  endfunction

  function automatic logic [ROW_W-1:0] set_cell(input logic [ROW_W-1:0] row,
                                                input logic [3:0] x,
                                                input logic [KIND_W-1:0] kind);
    set_cell = row;
    for (int i = 0; i < BOARD_W; i++) begin
      if (32'(x) == i) set_cell[i*KIND_W +: KIND_W] = kind;
    end
  endfunction

endpackage

// File: rtl/bcd_inc4.sv
// Combinational 4-digit BCD +1 that holds at 9999 instead of wrapping.
// Ports: value (16 b BCD in), result (16 b BCD out, digit 3 in [15:12]).
// Zero latency; no flow control.
module bcd_inc4 (
  input  logic [15:0] value,
  output logic [15:0] result
);

  logic carry;

  always_comb begin
    result = value;
    carry  = 1'b1;
    if (value != 16'h9999) begin
      // Ripple the +1 up through the digits; a 9 rolls to 0 and carries.
      for (int d = 0; d < 4; d++) begin
        if (carry) begin
          if (value[d*4 +: 4] == 4'd9) begin
            result[d*4 +: 4] = 4'd0;
          end else begin
            result[d*4 +: 4] = value[d*4 +: 4] + 4'd1;
            carry            = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/board_ctrl.sv
// Tetris playfield store, display cell lookup, game writes and row-removal sequencer.
// Ports: clk/reset_n; disp_x/disp_y -> disp_kind (1-cycle); wr_valid/wr_ready/wr_x/wr_y/wr_kind;
//        commit, clear_board; busy, commit_done, lines_cleared, score (BCD).
module board_ctrl
  import board_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  disp_x,
  input  logic [4:0]  disp_y,
  output logic [3:0]  disp_kind,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_x,
  input  logic [4:0]  wr_y,
  input  logic [2:0]  wr_kind,
  input  logic        commit,
  input  logic        clear_board,
  output logic        busy,
  output logic        commit_done,
  output logic [4:0]  lines_cleared,
  output logic [15:0] score
);

  logic [ROW_W-1:0] rows [BOARD_H];
  state_t           state;
  logic [4:0]       r;
  logic [4:0]       k;
  logic [15:0]      score_inc;

  // Single row-write port shared by the shifter and game writes.
  logic             row_we;
  logic [4:0]       row_sel;
  logic [ROW_W-1:0] row_wdata;
  logic             wr_hit;

  bcd_inc4 u_bcd_inc4 (
    .value  (score),
    .result (score_inc)
  );

  assign wr_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Out-of-range coordinates still complete the handshake but write nothing.
  assign wr_hit = wr_valid && wr_ready &&
                  (wr_x < 4'(BOARD_W)) && (wr_y < 5'(BOARD_H));

  // Game writes only happen in IDLE and the shifter only in SHIFT, so the
  // state alone arbitrates the row-write port.
  always_comb begin
    row_we    = 1'b0;
    row_sel   = '0;
    row_wdata = '0;
    if (state == SHIFT) begin
      row_we    = 1'b1;
      row_sel   = k;
      row_wdata = (k == 5'd0) ? '0 : rows[k - 5'd1];
    end else if (wr_hit) begin
      row_we    = 1'b1;
      row_sel   = wr_y;
      row_wdata = set_cell(rows[wr_y], wr_x, wr_kind);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < BOARD_H; i++) rows[i] <= '0;
      state         <= IDLE;
      r             <= '0;
      k             <= '0;
      disp_kind     <= '0;
      commit_done   <= 1'b0;
      lines_cleared <= '0;
      score         <= '0;
    end else begin
      // Display lookup never stalls; mid-shift reads may see mixed rows.
      if ((disp_x < 4'(BOARD_W)) && (disp_y < 5'(BOARD_H)))
        disp_kind <= 4'(cell_at(rows[disp_y], disp_x));
      else
        disp_kind <= '0;

      if (clear_board) begin
        // Overrides everything, including a same-cycle write or commit.
        for (int i = 0; i < BOARD_H; i++) rows[i] <= '0;
        state         <= IDLE;
        commit_done   <= 1'b0;
        lines_cleared <= '0;
        score         <= '0;
      end else begin
        commit_done <= 1'b0;
        if (row_we) rows[row_sel] <= row_wdata;

        case (state)
          IDLE: begin
            if (commit) begin
              r             <= 5'(BOARD_H - 1);
              lines_cleared <= '0;
              state         <= SCAN;
            end
          end
          SCAN: begin
            if (row_full(rows[r])) begin
              k     <= r;
              state <= SHIFT;
              score <= score_inc;
              if (lines_cleared != 5'(BOARD_H)) lines_cleared <= lines_cleared + 5'd1;
            end else if (r == 5'd0) begin
              state       <= DONE;
              commit_done <= 1'b1;
            end else begin
              r <= r - 5'd1;
            end
          end
          SHIFT: begin
            // r is left alone so the row shifted into it is rescanned.
            if (k == 5'd0) state <= SCAN;
            else           k     <= k - 5'd1;
          end
          DONE: begin
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_board_ctrl.sv
// Directed self-checking bench for board_ctrl (plus a few direct bcd_inc4 vectors).
// Ports: none.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_board_ctrl;

  logic        clk;
  logic        reset_n;
  logic [3:0]  disp_x;
  logic [4:0]  disp_y;
  logic [3:0]  disp_kind;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_x;
  logic [4:0]  wr_y;
  logic [2:0]  wr_kind;
  logic        commit;
  logic        clear_board;
  logic        busy;
  logic        commit_done;
  logic [4:0]  lines_cleared;
  logic [15:0] score;
  logic [15:0] inc_in;
  logic [15:0] inc_out;

  int n_checks = 0;
  int n_fail   = 0;

  board_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .disp_x        (disp_x),
    .disp_y        (disp_y),
    .disp_kind     (disp_kind),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_x          (wr_x),
    .wr_y          (wr_y),
    .wr_kind       (wr_kind),
    .commit        (commit),
    .clear_board   (clear_board),
    .busy          (busy),
    .commit_done   (commit_done),
    .lines_cleared (lines_cleared),
    .score         (score)
  );

  bcd_inc4 u_inc (
    .value  (inc_in),
    .result (inc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_cell(input int x, input int y, output logic [3:0] kind);
    disp_x = 4'(x);
    disp_y = 5'(y);
    tick();
    kind = disp_kind;
  endtask

  task automatic write_cell(input int x, input int y, input int kind);
    wr_valid = 1'b1;
    wr_x     = 4'(x);
    wr_y     = 5'(y);
    wr_kind  = 3'(kind);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic fill_row(input int y, input int kind);
    for (int x = 0; x < 10; x++) write_cell(x, y, kind);
  endtask

  // Pulses commit (edge 0) and returns the cycle number, counted from 1 for
  // the first cycle after edge 0, in which commit_done is seen high.
  task automatic do_commit(output int cyc, output logic busy1);
    commit = 1'b1;
    tick();
    commit   = 1'b0;
    wr_valid = 1'b0;
    busy1    = busy;
    cyc      = 1;
    while (commit_done !== 1'b1 && cyc < 2000) begin
      tick();
      cyc++;
    end
    check("commit_done_seen", {31'd0, commit_done}, 32'd1);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  initial begin
    logic [3:0] kind;
    logic       busy1;
    logic       seen;
    int         cyc;

    reset_n = 1'b0; disp_x = '0; disp_y = '0; wr_valid = 1'b0; wr_x = '0;
    wr_y = '0; wr_kind = '0; commit = 1'b0; clear_board = 1'b0; inc_in = '0;

    // Reset state
    tick(); tick();
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_commit_done", {31'd0, commit_done}, 32'd0);
    check("rst_lines", {27'd0, lines_cleared}, 32'd0);
    check("rst_score", {16'd0, score}, 32'h0000);
    check("rst_disp_kind", {28'd0, disp_kind}, 32'd0);
    reset_n = 1'b1;

    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 10; x++) begin
        read_cell(x, y, kind);
        check($sformatf("empty_%0d_%0d", x, y), {28'd0, kind}, 32'd0);
      end
    read_cell(10, 0, kind); check("oor_x10", {28'd0, kind}, 32'd0);
    read_cell(0, 20, kind); check("oor_y20", {28'd0, kind}, 32'd0);

    // Single write, 1-cycle read latency
    disp_x = 4'd3; disp_y = 5'd7;
    wr_valid = 1'b1; wr_x = 4'd3; wr_y = 5'd7; wr_kind = 3'd5;
    tick();
    wr_valid = 1'b0;
    check("rd_before_write", {28'd0, disp_kind}, 32'd0);
    tick();
    check("rd_after_write", {28'd0, disp_kind}, 32'd5);

    // Out-of-range write: handshake completes, board unchanged
    wr_valid = 1'b1; wr_x = 4'd12; wr_y = 5'd4; wr_kind = 3'd7;
    #1 check("oor_wr_ready", {31'd0, wr_ready}, 32'd1);
    tick();
    wr_valid = 1'b0;
    for (int x = 0; x < 10; x++) begin
      read_cell(x, 4, kind);
      check($sformatf("oor_row4_%0d", x), {28'd0, kind}, 32'd0);
    end
    write_cell(3, 7, 0);
    read_cell(3, 7, kind); check("erase_3_7", {28'd0, kind}, 32'd0);

    // Commit with no full rows
    do_commit(cyc, busy1);
    check("empty_busy_c1", {31'd0, busy1}, 32'd1);
    check("empty_done_cycle", 32'(cyc), 32'd21);
    check("empty_lines", {27'd0, lines_cleared}, 32'd0);
    tick();
    check("empty_ready_c22", {31'd0, wr_ready}, 32'd1);
    check("empty_done_low", {31'd0, commit_done}, 32'd0);

    // Row 19 completed by a write in the commit cycle; (0,18)=2 drops to row 19
    for (int x = 0; x < 9; x++) write_cell(x, 19, 1);
    write_cell(0, 18, 2);
    wr_valid = 1'b1; wr_x = 4'd9; wr_y = 5'd19; wr_kind = 3'd1;
    do_commit(cyc, busy1);
    check("one_done_cycle", 32'(cyc), 32'd42);
    check("one_lines", {27'd0, lines_cleared}, 32'd1);
    check("one_score", {16'd0, score}, 32'h0001);
    tick();
    check("one_idle", {31'd0, busy}, 32'd0);
    read_cell(0, 19, kind); check("one_0_19", {28'd0, kind}, 32'd2);
    read_cell(1, 19, kind); check("one_1_19", {28'd0, kind}, 32'd0);
    read_cell(0, 18, kind); check("one_0_18", {28'd0, kind}, 32'd0);
    read_cell(0, 0, kind);  check("one_0_0", {28'd0, kind}, 32'd0);

    // Rows 18,19 full; a write raised during the sequence must wait
    fill_row(18, 3);
    fill_row(19, 3);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    wr_valid = 1'b1; wr_x = 4'd5; wr_y = 5'd0; wr_kind = 3'd4;
    seen = 1'b0;
    cyc = 1;
    while (commit_done !== 1'b1 && cyc < 2000) begin
      if (wr_ready) seen = 1'b1;
      tick();
      cyc++;
    end
    check("two_done_cycle", 32'(cyc), 32'd63);
    check("two_ready_while_busy", {31'd0, seen}, 32'd0);
    check("two_lines", {27'd0, lines_cleared}, 32'd2);
    check("two_score", {16'd0, score}, 32'h0003);
    tick();
    check("two_ready_idle", {31'd0, wr_ready}, 32'd1);
    tick();
    wr_valid = 1'b0;
    read_cell(5, 0, kind);  check("held_write_5_0", {28'd0, kind}, 32'd4);
    read_cell(0, 19, kind); check("two_0_19", {28'd0, kind}, 32'd0);
    read_cell(9, 18, kind); check("two_9_18", {28'd0, kind}, 32'd0);
    write_cell(5, 0, 0);

    // Whole board full: 20 rows, lines_cleared caps at 20
    for (int y = 0; y < 20; y++) fill_row(y, (y % 7) + 1);
    do_commit(cyc, busy1);
    check("full_done_cycle", 32'(cyc), 32'd441);
    check("full_lines", {27'd0, lines_cleared}, 32'd20);
    check("full_score", {16'd0, score}, 32'h0023);
    tick();
    read_cell(0, 0, kind);  check("full_0_0", {28'd0, kind}, 32'd0);
    read_cell(9, 19, kind); check("full_9_19", {28'd0, kind}, 32'd0);
    read_cell(4, 10, kind); check("full_4_10", {28'd0, kind}, 32'd0);

    // Single-row commits from 23 up to 99, then the BCD carry into hundreds
    for (int i = 0; i < 76; i++) begin
      fill_row(19, 6);
      do_commit(cyc, busy1);
      tick();
      check($sformatf("step_score_%0d", 24 + i), {16'd0, score}, {16'd0, to_bcd(24 + i)});
    end
    check("score_0099", {16'd0, score}, 32'h0099);
    fill_row(19, 6);
    do_commit(cyc, busy1);
    check("score_0100", {16'd0, score}, 32'h0100);
    tick();

    // clear_board mid-SHIFT, with a same-cycle write that must be dropped
    fill_row(19, 1);
    write_cell(2, 10, 5);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick(); tick(); tick(); tick();
    check("pre_clear_busy", {31'd0, busy}, 32'd1);
    clear_board = 1'b1;
    wr_valid = 1'b1; wr_x = 4'd1; wr_y = 5'd1; wr_kind = 3'd6;
    tick();
    clear_board = 1'b0;
    wr_valid = 1'b0;
    check("clr_busy", {31'd0, busy}, 32'd0);
    check("clr_score", {16'd0, score}, 32'h0000);
    check("clr_lines", {27'd0, lines_cleared}, 32'd0);
    check("clr_commit_done", {31'd0, commit_done}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (commit_done) seen = 1'b1;
      tick();
    end
    check("clr_no_done_pulse", {31'd0, seen}, 32'd0);
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 10; x++) begin
        read_cell(x, y, kind);
        check($sformatf("clr_%0d_%0d", x, y), {28'd0, kind}, 32'd0);
      end

    // clear_board in IDLE drops both a write and a commit
    clear_board = 1'b1; commit = 1'b1;
    wr_valid = 1'b1; wr_x = 4'd1; wr_y = 5'd1; wr_kind = 3'd6;
    tick();
    clear_board = 1'b0; commit = 1'b0; wr_valid = 1'b0;
    check("clr_commit_dropped", {31'd0, busy}, 32'd0);
    read_cell(1, 1, kind); check("clr_write_dropped", {28'd0, kind}, 32'd0);

    // BCD incrementer vectors, including saturation at 9999
    inc_in = 16'h9999; #1 check("bcd_9999", {16'd0, inc_out}, 32'h9999);
    inc_in = 16'h0999; #1 check("bcd_0999", {16'd0, inc_out}, 32'h1000);
    inc_in = 16'h9998; #1 check("bcd_9998", {16'd0, inc_out}, 32'h9999);
    inc_in = 16'h1234; #1 check("bcd_1234", {16'd0, inc_out}, 32'h1235);
    inc_in = 16'h0089; #1 check("bcd_0089", {16'd0, inc_out}, 32'h0090);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
